rgb_frame_feeder: RTL and testbench

Upstream stage of rgb_driver. Buffers 24-bit RGB pixels in a small FIFO and serialises each pixel into three bytes in G, R, B order. Presents one byte at a time to the driver's data/en inputs and advances on the driver's byte-complete pulse. After NUM_LEDS pixels, or on FIFO underrun, it holds the line idle for the LED latch/reset gap, then signals frame completion.

---
 rtl/rgb_frame_feeder_if.sv | 20 ++
 rtl/rgb_frame_feeder.sv | 151 +++++++++++++++
 tb/tb_rgb_frame_feeder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_frame_feeder_if.sv
// Pixel-write and driver-byte handshake bundle for rgb_frame_feeder.
// The master side is the upstream pixel source together with the downstream driver.
interface rgb_frame_feeder_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        drv_done;
    logic        drv_en;
    logic [7:0]  drv_data;

    modport master (
        output pix_valid, pix_data, drv_done,
        input  pix_ready, drv_en, drv_data
    );

    modport slave (
        input  pix_valid, pix_data, drv_done,
        output pix_ready, drv_en, drv_data
    );
endinterface

// File: rtl/rgb_frame_feeder.sv
// Pixel FIFO plus G/R/B byte serialiser feeding rgb_driver.
// Each frame ends with a forced idle latch gap and a one-cycle frame_done pulse.
module rgb_frame_feeder #(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LATCH_CYCLES = 6000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    rgb_frame_feeder_if.slave   bus,
    output logic                busy,
    output logic                underrun,
    output logic                frame_done,
    output logic [15:0]         led_index
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(LATCH_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LATCH_CYCLES - 1);
    localparam logic [15:0]   LAST_IDX = 16'(NUM_LEDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_LATCH} state_t;

    state_t        state, state_nx;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [23:0]   pix_reg;
    logic          pix_ld;
    logic [1:0]    byte_idx, byte_nx;
    logic [15:0]   idx_nx;
    logic [CW-1:0] latch_cnt, cnt_nx;
    logic          urun_nx;
    logic          drv_en_c;
    logic [7:0]    drv_data_c;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.pix_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.pix_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= S_IDLE;
            pix_reg   <= '0;
            byte_idx  <= '0;
            led_index <= '0;
            latch_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pix_ld) begin
                pix_reg <= mem[rd_ptr[AW-1:0]];
            end
            state     <= state_nx;
            byte_idx  <= byte_nx;
            led_index <= idx_nx;
            latch_cnt <= cnt_nx;
            underrun  <= urun_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        pix_ld     = 1'b0;
        byte_nx    = byte_idx;
        idx_nx     = led_index;
        cnt_nx     = latch_cnt;
        urun_nx    = underrun;
        drv_en_c   = 1'b0;
        drv_data_c = '0;
        frame_done = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    urun_nx  = 1'b0;
                    idx_nx   = '0;
                end
            end
            S_LOAD: begin
                if (!empty) begin
                    pop      = 1'b1;
                    pix_ld   = 1'b1;
                    byte_nx  = '0;
                    state_nx = S_SEND;
                end else begin
                    urun_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_LATCH;
                end
            end
            S_SEND: begin
                drv_en_c = 1'b1;
                unique case (byte_idx)
                    2'd0:    drv_data_c = pix_reg[15:8];
                    2'd1:    drv_data_c = pix_reg[23:16];
                    default: drv_data_c = pix_reg[7:0];
                endcase
                if (bus.drv_done) begin
                    if (byte_idx != 2'd2) begin
                        byte_nx = byte_idx + 2'd1;
                    end else if (led_index == LAST_IDX) begin
                        cnt_nx   = '0;
                        state_nx = S_LATCH;
                    end else if (!empty) begin
                        // Reload straight into SEND so the driver sees no enable gap.
                        pop     = 1'b1;
                        pix_ld  = 1'b1;
                        idx_nx  = led_index + 16'd1;
                        byte_nx = '0;
                    end else begin
                        urun_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                if (latch_cnt == LAST_CNT) begin
                    frame_done = 1'b1;
                    idx_nx     = '0;
                    state_nx   = S_IDLE;
                end else begin
                    cnt_nx = latch_cnt + CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy          = (state != S_IDLE);
    assign bus.pix_ready = !full;
    assign bus.drv_en    = drv_en_c;
    assign bus.drv_data  = drv_data_c;
endmodule

// File: tb/tb_rgb_frame_feeder.sv
// Randomised bench for rgb_frame_feeder: a pixel queue model plus G/R/B byte
// ordering rules predict every byte, FIFO readiness, underrun and latch timing.
module tb_rgb_frame_feeder;
    localparam int unsigned N = 3;
    localparam int unsigned D = 4;
    localparam int unsigned L = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, underrun, frame_done;
    logic [15:0] led_index;

    int errors = 0;
    int checks = 0;
    logic [23:0] q[$];
    bit wr_mode = 1'b0;

    rgb_frame_feeder_if bus();

    rgb_frame_feeder #(.NUM_LEDS(N), .FIFO_DEPTH(D), .LATCH_CYCLES(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .underrun   (underrun),
        .frame_done (frame_done),
        .led_index  (led_index)
    );

    always #5 clk = ~clk;

    // One clock cycle: pop happens on pre-edge contents, then an accepted write appends.
    task automatic step(input bit do_pop, output bit got, output logic [23:0] px);
        int unsigned pre;
        bit wr;
        logic [23:0] wdata;
        pre   = q.size();
        wr    = bus.pix_valid;
        wdata = bus.pix_data;
        if (wr) begin
            checks++;
            if (bus.pix_ready !== (pre < D)) begin
                errors++;
                $display("FAIL pix_ready: got %b want %b (occupancy %0d)", bus.pix_ready, (pre < D), pre);
            end
        end
        @(posedge clk);
        #1;
        got = 1'b0;
        px  = '0;
        if (do_pop && pre > 0) begin
            px  = q.pop_front();
            got = 1'b1;
        end
        if (wr && pre < D) q.push_back(wdata);
        if (wr_mode) begin
            bus.pix_valid = ($urandom_range(0, 2) == 0);
            bus.pix_data  = 24'($urandom);
        end
    endtask

    task automatic push_px(input logic [23:0] p);
        bit g;
        logic [23:0] d;
        bus.pix_valid = 1'b1;
        bus.pix_data  = p;
        step(1'b0, g, d);
        bus.pix_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        bit got, g2, g0, exp_ur, more;
        logic [23:0] px, nx, d0;
        logic [7:0] want;
        int unsigned n, k;
        start = 1'b1;
        step(1'b0, g0, d0);
        start = 1'b0;
        checks++;
        if ({busy, bus.drv_en, underrun} !== 3'b100) begin
            errors++;
            $display("FAIL %s load_state: busy/en/underrun got %b want 100", tag, {busy, bus.drv_en, underrun});
        end
        step(1'b1, got, px);
        exp_ur = !got;
        more   = got;
        n      = 0;
        while (more) begin
            for (int b = 0; b < 3; b++) begin
                want = (b == 0) ? px[15:8] : (b == 1) ? px[23:16] : px[7:0];
                checks++;
                if ({bus.drv_en, bus.drv_data, led_index} !== {1'b1, want, 16'(n)}) begin
                    errors++;
                    $display("FAIL %s byte: en/data/idx got %b/%h/%0d want 1/%h/%0d",
                             tag, bus.drv_en, bus.drv_data, led_index, want, n);
                end
                repeat ($urandom_range(0, 2)) begin
                    start = $urandom_range(0, 1);
                    step(1'b0, g0, d0);
                    checks++;
                    if ({bus.drv_en, bus.drv_data} !== {1'b1, want}) begin
                        errors++;
                        $display("FAIL %s hold: en/data got %b/%h want 1/%h", tag, bus.drv_en, bus.drv_data, want);
                    end
                end
                start = 1'b0;
                bus.drv_done = 1'b1;
                step((b == 2) && (n != N - 1), g2, nx);
                bus.drv_done = 1'b0;
            end
            if (n == N - 1) more = 1'b0;
            else if (g2) begin
                px = nx;
                n++;
            end else begin
                exp_ur = 1'b1;
                more   = 1'b0;
            end
        end
        checks++;
        if ({bus.drv_en, busy, underrun} !== {1'b0, 1'b1, exp_ur}) begin
            errors++;
            $display("FAIL %s latch_entry: en/busy/underrun got %b want %b", tag,
                     {bus.drv_en, busy, underrun}, {1'b0, 1'b1, exp_ur});
        end
        k = 0;
        while (frame_done !== 1'b1 && k < L + 4) begin
            start = $urandom_range(0, 1);
            step(1'b0, g0, d0);
            k++;
            checks++;
            if (bus.drv_en !== 1'b0) begin
                errors++;
                $display("FAIL %s latch_idle: drv_en got %b want 0", tag, bus.drv_en);
            end
        end
        start = 1'b0;
        checks++;
        if (k !== L - 1) begin
            errors++;
            $display("FAIL %s frame_done_latency: got %0d want %0d", tag, k, L - 1);
        end
        step(1'b0, g0, d0);
        checks++;
        if ({busy, frame_done, bus.drv_en, led_index} !== {3'b000, 16'd0}) begin
            errors++;
            $display("FAIL %s back_to_idle: busy/fd/en got %b idx %0d want 000 idx 0", tag,
                     {busy, frame_done, bus.drv_en}, led_index);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, underrun, frame_done, bus.drv_en, bus.drv_data, led_index} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy/ur/fd/en %b data %h idx %0d want all zero",
                     {busy, underrun, frame_done, bus.drv_en}, bus.drv_data, led_index);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.pix_ready, busy, bus.drv_en} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: ready/busy/en got %b want 100", {bus.pix_ready, busy, bus.drv_en});
        end
    endtask

    task automatic test_back_to_back();
        push_px(24'hAA0000);
        push_px(24'h00BB00);
        push_px(24'h0000CC);
        run_frame("back_to_back");
    endtask

    task automatic test_underrun();
        push_px(24'($urandom));
        push_px(24'($urandom));
        run_frame("underrun");
    endtask

    task automatic test_empty_start();
        run_frame("empty_start");
    endtask

    task automatic test_underrun_clear();
        for (int i = 0; i < 3; i++) push_px(24'($urandom));
        run_frame("underrun_clear");
    endtask

    task automatic test_fifo_full();
        bit g;
        logic [23:0] d;
        for (int i = 0; i < 5; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 24'($urandom);
            checks++;
            if (bus.pix_ready !== (i < 4)) begin
                errors++;
                $display("FAIL fifo_full_ready: write %0d got %b want %b", i, bus.pix_ready, (i < 4));
            end
            step(1'b0, g, d);
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_overlap();
        wr_mode = 1'b1;
        for (int i = 0; i < 4; i++) run_frame("overlap");
        wr_mode = 1'b0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit g;
        logic [23:0] d;
        push_px(24'($urandom));
        start = 1'b1;
        step(1'b0, g, d);
        start = 1'b0;
        step(1'b1, g, d);
        checks++;
        if (bus.drv_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_send: drv_en got %b want 1", bus.drv_en);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.drv_en, busy, underrun, frame_done, bus.pix_ready, led_index, bus.drv_data} !==
            {5'b00001, 16'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_async: en/busy/ur/fd/ready got %b idx %0d data %h want 00001 0 00",
                     {bus.drv_en, busy, underrun, frame_done, bus.pix_ready}, led_index, bus.drv_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        checks++;
        if ({bus.drv_en, busy, underrun, bus.pix_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_after_release: en/busy/ur/ready got %b want 0001",
                     {bus.drv_en, busy, underrun, bus.pix_ready});
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.drv_done  = 1'b0;
        test_reset();
        test_back_to_back();
        test_underrun();
        test_empty_start();
        test_underrun_clear();
        test_fifo_full();
        test_overlap();
        test_reset_mid_frame();
        test_empty_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
